uart_tx_configurable: RTL and testbench
=======================================

UART_TX_CONFIGURABLE -- requirements
Module: uart_tx_configurable

Interface
REQ-001 SHALL provide parameter TRANS_INTERVAL, default 10000, clock cycles per serial bit (legal >= 2).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-003 SHALL provide parameter PARITY, default PARITY_NONE, parity mode (PARITY_NONE / PARITY_EVEN / PARITY_ODD).
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-005 SHALL provide parameter FIFO_DEPTH, default 4, transmit buffer entries (power of two, >= 2).
REQ-006 SHALL have port clk, input, 1 bit, clock; reset reset, synchronous, active-high; clock clk.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port uart_tx, output, 1 bit, serial line, idle high.
REQ-009 SHALL have port data, input, 8 bits, byte to enqueue.
REQ-010 SHALL have port ok, input, 1 bit, single-cycle push strobe for data.
REQ-011 SHALL have port busy, output, 1 bit, FIFO full; pushes refused.
REQ-012 SHALL have port idle, output, 1 bit, FIFO empty and no frame in progress.

Function
REQ-013 SHALL accept a push when ok=1 and busy=0 at a rising edge; ok with busy=1 SHALL drop the byte silently.
REQ-014 SHALL evaluate busy from registered FIFO occupancy only; a same-cycle pop SHALL NOT admit a push while full.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE with FIFO non-empty SHALL pop one entry and enter START; uart_tx=0 from the next cycle.
REQ-017 Every bit (start, data, parity, each stop) SHALL be held exactly TRANS_INTERVAL cycles.
REQ-018 DATA SHALL send data[0] through data[DATA_BITS-1], LSB first; bits above DATA_BITS-1 SHALL be ignored.
REQ-019 PARITY SHALL be skipped when PARITY_NONE; even = XOR of sent data bits; odd = its inverse.
REQ-020 STOP SHALL drive 1 for STOP_BITS x TRANS_INTERVAL cycles.
REQ-021 At end of STOP with FIFO non-empty, SHALL pop and enter START directly; no extra idle cycle between frames.
REQ-022 At end of STOP with FIFO empty, SHALL enter IDLE with uart_tx=1.
REQ-023 Bit counter width SHALL be $clog2(DATA_BITS); interval counter SHALL be 32 bits and compare count+1 < TRANS_INTERVAL.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-025 Push and pop in the same cycle (not full) SHALL leave occupancy unchanged and preserve order.
REQ-026 idle SHALL be 1 only in IDLE with FIFO empty.

Reset
REQ-027 Reset SHALL force uart_tx=1, busy=0, idle=1, state IDLE, FIFO empty, counters 0, from the next cycle.
REQ-028 Reset mid-frame SHALL abort the frame immediately and discard all buffered bytes.
REQ-029 ok asserted together with reset SHALL be ignored.

Structure
REQ-030 Package uart_pkg SHALL hold parity_t enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD) and the tx state enum.
REQ-031 The FIFO SHALL be sub-module uart_tx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/dout).
REQ-032 The FSM and bit/interval counters SHALL reside in uart_tx_configurable.

Verification (TRANS_INTERVAL=4 unless stated)
REQ-033 8N1, push 0x55 -> uart_tx 0,1,0,1,0,1,0,1,0,1, each 4 cycles, then idle=1 after 40 cycles.
REQ-034 7E2, push 0xC3 (sends 0x43) -> start, 1,1,0,0,0,0,1, parity 1, two stop bits; 0x80 bit not sent.
REQ-035 8O1, push 0x00 -> parity bit 1; 8E1, push 0xFF -> parity bit 0.
REQ-036 FIFO_DEPTH=4, push 6 bytes in 6 consecutive cycles -> 5 accepted (one popped in flight), sixth dropped with busy=1; frames back-to-back, start bit directly after 4-cycle stop.
REQ-037 Reset asserted mid-DATA of first of 3 queued bytes -> uart_tx=1 next cycle, idle=1, no further frames.
REQ-038 Push on same cycle as pop with FIFO at 3/4 -> occupancy stays 3, byte order preserved on line.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the configurable UART transmitter.
//   parity_t     - parity mode selected by the transmitter's PARITY parameter
//   tx_state_t   - serialiser state; also driven on the state_dbg port
//   calc_parity  - parity bit for a (pre-masked) data byte in a given mode
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  // TX_ prefix keeps the state literals clear of the PARITY parameter name.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Even parity is the XOR of the transmitted data bits; odd is its inverse.
  // Callers mask off unsent bits first so they do not disturb the result.
  function automatic logic calc_parity(input logic [7:0] bits, input parity_t mode);
    return (mode == PARITY_ODD) ? ~(^bits) : (^bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO buffering bytes for the transmitter.
// First-word fall-through: dout always shows the oldest entry while !empty.
//   clk, reset  - clock, synchronous active-high reset (empties the FIFO)
//   push, din   - write din when push=1 and the FIFO is not full
//   pop         - drop the oldest entry when pop=1 and the FIFO is not empty
//   dout        - oldest entry
//   full, empty - decoded from the registered occupancy count only, so a
//                 pop in the same cycle never makes room for a push while full
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_configurable.sv
// uart_tx_configurable: buffered UART transmitter with configurable framing.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits(1). Every bit lasts TRANS_INTERVAL clock cycles.
//   clk, reset - clock, synchronous active-high reset (aborts the frame and
//                discards buffered bytes)
//   uart_tx    - serial line, idle high, registered
//   data, ok   - push interface: ok is a single-cycle strobe; the byte is
//                accepted at a rising edge where ok=1 and busy=0; with
//                busy=1 it is dropped silently; there is no back-pressure
//                beyond busy
//   busy       - FIFO full
//   idle       - FIFO empty and no frame in progress
//   state_dbg  - current serialiser state (tx_state_t encoding)
module uart_tx_configurable
  import uart_pkg::*;
#(
  parameter int      TRANS_INTERVAL = 10000,
  parameter int      DATA_BITS      = 8,
  parameter parity_t PARITY         = PARITY_NONE,
  parameter int      STOP_BITS      = 1,
  parameter int      FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       uart_tx,
  input  logic [7:0] data,
  input  logic       ok,
  output logic       busy,
  output logic       idle,
  output logic [2:0] state_dbg
);

  localparam int               BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [31:0]      INTERVAL  = 32'(TRANS_INTERVAL);

  tx_state_t        state;
  logic [BIT_W-1:0] bit_cnt;
  logic [31:0]      int_cnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             stop_cnt;

  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       bit_done;
  logic       stop_done;
  logic [7:0] masked_dout;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ok),
    .din   (data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Last cycle of the current bit cell.
  assign bit_done    = !((int_cnt + 32'd1) < INTERVAL);
  assign stop_done   = !(({1'b0, stop_cnt} + 2'd1) < 2'(STOP_BITS));
  assign masked_dout = fifo_dout & DATA_MASK;

  // Pop when idle, or at the very end of the last stop bit so the next
  // start bit follows without a gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == TX_IDLE) ||
                     (state == TX_STOP && bit_done && stop_done));

  assign busy      = fifo_full;
  assign idle      = (state == TX_IDLE) && fifo_empty;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      uart_tx  <= 1'b1;
      bit_cnt  <= '0;
      int_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          int_cnt <= '0;
          if (fifo_pop) begin
            shreg    <= masked_dout;
            par_bit  <= calc_parity(masked_dout, PARITY);
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            uart_tx  <= 1'b0;
            state    <= TX_START;
          end
        end

        TX_START: begin
          if (bit_done) begin
            int_cnt <= '0;
            bit_cnt <= '0;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= TX_DATA;
          end else begin
            int_cnt <= int_cnt + 32'd1;
          end
        end

        TX_DATA: begin
          if (bit_done) begin
            int_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (PARITY != PARITY_NONE) begin
                uart_tx <= par_bit;
                state   <= TX_PARITY;
              end else begin
                uart_tx  <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= TX_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            int_cnt <= int_cnt + 32'd1;
          end
        end

        TX_PARITY: begin
          if (bit_done) begin
            int_cnt  <= '0;
            uart_tx  <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= TX_STOP;
          end else begin
            int_cnt <= int_cnt + 32'd1;
          end
        end

        TX_STOP: begin
          if (bit_done) begin
            int_cnt <= '0;
            if (!stop_done) begin
              stop_cnt <= 1'b1;
            end else if (fifo_pop) begin
              shreg    <= masked_dout;
              par_bit  <= calc_parity(masked_dout, PARITY);
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              uart_tx  <= 1'b0;
              state    <= TX_START;
            end else begin
              uart_tx <= 1'b1;
              state   <= TX_IDLE;
            end
          end else begin
            int_cnt <= int_cnt + 32'd1;
          end
        end

        default: begin
          uart_tx <= 1'b1;
          int_cnt <= '0;
          state   <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_configurable.sv
// Bench for uart_tx_configurable: four instances (8N1, 7E2, 8O1, 8E1) at
// four clocks per bit. Directed pushes put hand-computed frames into
// per-instance expected queues; per-instance monitors decode the serial
// line cycle by cycle and compare against the queue heads.
// Queue entry: [9] frame must start directly after previous stop,
//              [8] expected parity bit, [7:0] data bits as sent.
module tb_uart_tx_configurable;
  import uart_pkg::*;

  localparam int TI = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst;
  logic [3:0] ok;
  logic [7:0] din [4];
  wire  [3:0] tx_line;
  wire  [3:0] busy;
  wire  [3:0] idle;
  wire  [2:0] st0, st1, st2, st3;

  int checks = 0;
  int errors = 0;
  logic [3:0] mon_en;

  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];
  logic [9:0] exp_q3[$];

  int cfg_db  [4] = '{8, 7, 8, 8};
  int cfg_par [4] = '{0, 1, 1, 1};
  int cfg_sb  [4] = '{1, 2, 1, 1};

  uart_tx_configurable #(.TRANS_INTERVAL(TI), .DATA_BITS(8), .PARITY(PARITY_NONE),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(rst[0]), .uart_tx(tx_line[0]), .data(din[0]), .ok(ok[0]),
    .busy(busy[0]), .idle(idle[0]), .state_dbg(st0));
  uart_tx_configurable #(.TRANS_INTERVAL(TI), .DATA_BITS(7), .PARITY(PARITY_EVEN),
                         .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(rst[1]), .uart_tx(tx_line[1]), .data(din[1]), .ok(ok[1]),
    .busy(busy[1]), .idle(idle[1]), .state_dbg(st1));
  uart_tx_configurable #(.TRANS_INTERVAL(TI), .DATA_BITS(8), .PARITY(PARITY_ODD),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(rst[2]), .uart_tx(tx_line[2]), .data(din[2]), .ok(ok[2]),
    .busy(busy[2]), .idle(idle[2]), .state_dbg(st2));
  uart_tx_configurable #(.TRANS_INTERVAL(TI), .DATA_BITS(8), .PARITY(PARITY_EVEN),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .reset(rst[3]), .uart_tx(tx_line[3]), .data(din[3]), .ok(ok[3]),
    .busy(busy[3]), .idle(idle[3]), .state_dbg(st3));

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int idx, input logic [9:0] e);
    case (idx)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      2: exp_q2.push_back(e);
      default: exp_q3.push_back(e);
    endcase
  endtask

  function automatic int sb_size(input int idx);
    case (idx)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  task automatic sb_pop(input int idx, output logic [9:0] e);
    case (idx)
      0: e = exp_q0.pop_front();
      1: e = exp_q1.pop_front();
      2: e = exp_q2.pop_front();
      default: e = exp_q3.pop_front();
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves ok high for exactly one rising edge.
  // Back-to-back calls give pushes on consecutive edges.
  task automatic push_byte(input int idx, input logic [7:0] b);
    din[idx] = b;
    ok[idx]  = 1'b1;
    @(negedge clk);
    ok[idx]  = 1'b0;
  endtask

  task automatic wait_idle(input int idx, input int budget);
    int n = 0;
    while (idle[idx] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_idle_%0d", idx), 32'(idle[idx]), 32'd1);
  endtask

  // ---------------- monitors ----------------
  task automatic run_monitor(input int idx);
    logic [9:0] e;
    logic [7:0] rx;
    logic       rx_par;
    logic       shape_ok;
    logic       exp_bit;
    int         gap;
    int         nbits;
    int         db;
    forever begin
      gap = 0;
      @(negedge clk);
      while (!(mon_en[idx] && tx_line[idx] === 1'b0)) begin
        gap++;
        @(negedge clk);
      end
      if (sb_size(idx) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_%0d: actual=start bit required=idle line", idx);
        while (tx_line[idx] !== 1'b1) @(negedge clk);
      end else begin
        sb_pop(idx, e);
        db       = cfg_db[idx];
        nbits    = 1 + db + cfg_par[idx] + cfg_sb[idx];
        rx       = '0;
        rx_par   = 1'b0;
        shape_ok = 1'b1;
        for (int b = 0; b < nbits; b++) begin
          if (b == 0)                            exp_bit = 1'b0;
          else if (b <= db)                      exp_bit = e[b-1];
          else if (cfg_par[idx] == 1 && b == db + 1) exp_bit = e[8];
          else                                   exp_bit = 1'b1;
          for (int c = 0; c < TI; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (tx_line[idx] !== exp_bit) shape_ok = 1'b0;
            if (c == TI / 2) begin
              if (b >= 1 && b <= db) rx[b-1] = tx_line[idx];
              else if (cfg_par[idx] == 1 && b == db + 1) rx_par = tx_line[idx];
            end
          end
        end
        check($sformatf("frame_data_%0d", idx), 32'(rx), 32'(e[7:0]));
        if (cfg_par[idx] == 1) check($sformatf("frame_parity_%0d", idx), 32'(rx_par), 32'(e[8]));
        check($sformatf("frame_timing_%0d", idx), 32'(shape_ok), 32'd1);
        if (e[9]) check($sformatf("back_to_back_gap_%0d", idx), 32'(gap), 32'd0);
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);
  initial run_monitor(2);
  initial run_monitor(3);

  // ---------------- stimulus ----------------
  logic [7:0] burst [6] = '{8'h11, 8'h22, 8'hA5, 8'h3C, 8'hF0, 8'h99};
  logic [7:0] ord   [5] = '{8'h01, 8'h80, 8'h7E, 8'hC4, 8'h5A};

  initial begin
    logic stayed_high;
    rst    = 4'hF;
    ok     = 4'h0;
    mon_en = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;

    // push attempted while reset is held must be ignored
    din[0] = 8'hAA;
    ok[0]  = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 4'h0;
    ok[0]  = 1'b0;
    mon_en = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_uart_tx_%0d", i), 32'(tx_line[i]), 32'd1);
      check($sformatf("reset_busy_%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("reset_idle_%0d", i), 32'(idle[i]), 32'd1);
    end
    check("reset_state_0", 32'(st0), 32'(TX_IDLE));
    check("reset_state_3", 32'(st3), 32'(TX_IDLE));
    repeat (20) @(negedge clk);
    check("ok_during_reset_ignored", 32'(idle[0]), 32'd1);

    // 8N1 0x55: alternating line, idle again exactly 40 cycles after the pop
    sb_push(0, {1'b0, 1'b0, 8'h55});
    push_byte(0, 8'h55);
    check("pre_start_line", 32'(tx_line[0]), 32'd1);
    check("pre_start_idle", 32'(idle[0]), 32'd0);
    @(negedge clk);
    check("start_bit_next_cycle", 32'(tx_line[0]), 32'd0);
    repeat (39) @(negedge clk);
    check("idle_low_at_cycle_39", 32'(idle[0]), 32'd0);
    @(negedge clk);
    check("idle_high_at_cycle_40", 32'(idle[0]), 32'd1);
    check("line_high_after_frame", 32'(tx_line[0]), 32'd1);

    // burst of six pushes into a depth-4 FIFO: five accepted, sixth dropped
    for (int k = 0; k < 6; k++) begin
      check($sformatf("burst_busy_%0d", k), 32'(busy[0]), (k == 5) ? 32'd1 : 32'd0);
      if (k < 5) sb_push(0, {(k > 0), 1'b0, burst[k]});
      push_byte(0, burst[k]);
    end
    check("burst_occupancy", 32'(dut0.u_fifo.count), 32'd4);
    wait_idle(0, 400);

    // occupancy 3 with push on the pop cycle: stays 3, order kept
    for (int k = 0; k < 4; k++) begin
      sb_push(0, {(k > 0), 1'b0, ord[k]});
      push_byte(0, ord[k]);
    end
    repeat (37) @(negedge clk);
    check("occupancy_before_pop", 32'(dut0.u_fifo.count), 32'd3);
    sb_push(0, {1'b1, 1'b0, ord[4]});
    push_byte(0, ord[4]);
    check("occupancy_push_pop_same_cycle", 32'(dut0.u_fifo.count), 32'd3);
    check("busy_after_push_pop", 32'(busy[0]), 32'd0);
    wait_idle(0, 400);

    // reset in the middle of the data bits of the first of three bytes
    mon_en[0] = 1'b0;
    push_byte(0, 8'h0F);
    push_byte(0, 8'hF0);
    push_byte(0, 8'h33);
    repeat (7) @(negedge clk);
    check("mid_data_state", 32'(st0), 32'(TX_DATA));
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort_uart_tx", 32'(tx_line[0]), 32'd1);
    check("abort_idle", 32'(idle[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_state", 32'(st0), 32'(TX_IDLE));
    check("abort_occupancy", 32'(dut0.u_fifo.count), 32'd0);
    stayed_high = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx_line[0] !== 1'b1 || idle[0] !== 1'b1) stayed_high = 1'b0;
    end
    check("no_frames_after_abort", 32'(stayed_high), 32'd1);
    mon_en[0] = 1'b1;
    @(negedge clk);
    sb_push(0, {1'b0, 1'b0, 8'h3C});
    push_byte(0, 8'h3C);
    wait_idle(0, 200);

    // 7E2: 0xC3 sends 0x43 (bit 7 dropped), parity 1; 0x80 sends 0x00, parity 0
    sb_push(1, {1'b0, 1'b1, 8'h43});
    sb_push(1, {1'b1, 1'b0, 8'h00});
    push_byte(1, 8'hC3);
    push_byte(1, 8'h80);
    wait_idle(1, 300);

    // 8O1: 0x00 -> parity 1; 0xA7 (five ones) -> parity 0
    sb_push(2, {1'b0, 1'b1, 8'h00});
    sb_push(2, {1'b1, 1'b0, 8'hA7});
    push_byte(2, 8'h00);
    push_byte(2, 8'hA7);
    wait_idle(2, 300);

    // 8E1: 0xFF -> parity 0; 0x01 -> parity 1
    sb_push(3, {1'b0, 1'b0, 8'hFF});
    sb_push(3, {1'b1, 1'b1, 8'h01});
    push_byte(3, 8'hFF);
    push_byte(3, 8'h01);
    wait_idle(3, 300);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("frames_outstanding_%0d", i), 32'(sb_size(i)), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
